johnson_counter_n: RTL and testbench

JOHNSON_COUNTER_N -- requirements
Module: johnson_counter_n

---
 rtl/johnson_counter_n.sv | 96 +++++++++
 tb/tb_johnson_counter_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/johnson_counter_n.sv
// Johnson (twisted-ring) counter with bidirectional stepping, index tracking,
// ring-wrap pulse, and optional self-correction of illegal patterns.
module johnson_counter_n #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1,
    localparam int IW          = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             wrap,
    output logic             err,
    output logic             illegal
);

    localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH - 1);

    // A Johnson code has at most one 0/1 boundary between adjacent bits.
    function automatic logic is_valid(input logic [WIDTH-1:0] v);
        int edges;
        edges = 0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    // Filling half counts ones upward; draining half counts remaining ones downward.
    function automatic logic [IW-1:0] index_of(input logic [WIDTH-1:0] v);
        int pop;
        pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) pop++;
        end
        if (v[0] || !v[WIDTH-1]) return IW'(pop);
        else                     return IW'(2*WIDTH - pop);
    endfunction

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] step_q;
    logic [IW-1:0]    idx_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    assign illegal = !is_valid(q);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        q_nxt    = q;
        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        step_q   = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};

        if (ld) begin
            if (is_valid(ld_val)) begin
                q_nxt   = ld_val;
                idx_nxt = index_of(ld_val);
            end else begin
                q_nxt   = SELF_CORRECT ? '0 : ld_val;
                idx_nxt = '0;
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (illegal && SELF_CORRECT) begin
                q_nxt   = '0;
                idx_nxt = '0;
            end else begin
                q_nxt    = step_q;
                idx_nxt  = is_valid(step_q) ? index_of(step_q) : '0;
                wrap_nxt = !illegal && (dir ? (idx == '0) : (idx == LAST_IDX));
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples the pre-edge values, independent of statement order.
        if (rst) begin
            q    <= '0;
            idx  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            q    <= q_nxt;
            idx  <= idx_nxt;
            wrap <= wrap_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_johnson_counter_n.sv
// Scoreboard bench: three counters (W4 self-correcting, W4 raw, W8) share control
// inputs; an index-arithmetic reference model predicts each edge's outputs.
module tb_johnson_counter_n;

    logic       clk = 1'b0;
    logic       rst, en, dir, ld;
    logic [3:0] ld_val4;
    logic [7:0] ld_val8;

    logic [3:0] q_a, q_b;
    logic [2:0] idx_a, idx_b;
    logic       wrap_a, wrap_b, err_a, err_b, ill_a, ill_b;
    logic [7:0] q_c;
    logic [3:0] idx_c;
    logic       wrap_c, err_c, ill_c;

    johnson_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val4),
        .q(q_a), .idx(idx_a), .wrap(wrap_a), .err(err_a), .illegal(ill_a));

    johnson_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val4),
        .q(q_b), .idx(idx_b), .wrap(wrap_b), .err(err_b), .illegal(ill_b));

    johnson_counter_n #(.WIDTH(8), .SELF_CORRECT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val8),
        .q(q_c), .idx(idx_c), .wrap(wrap_c), .err(err_c), .illegal(ill_c));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        int          idx;
        bit          wrap;
        bit          err;
    } st_t;

    st_t sb[$];
    st_t ma, mb, mc;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mask_of(input int w);
        return (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
    endfunction

    function automatic logic [15:0] code(input int k, input int w);
        if (k < w) return (16'h1 << k) - 16'h1;
        return (16'hFFFF << (k - w)) & mask_of(w);
    endfunction

    function automatic int lookup(input logic [15:0] v, input int w);
        for (int k = 0; k < 2*w; k++) begin
            if (code(k, w) == v) return k;
        end
        return -1;
    endfunction

    function automatic st_t model_step(input st_t s, input bit r, input bit l, input bit e,
                                       input bit d, input logic [15:0] lv, input int w,
                                       input bit sc);
        st_t n;
        int  k, nk;
        n = s;
        n.wrap = 1'b0;
        n.err  = 1'b0;
        if (r) begin
            n.q = '0;
            n.idx = 0;
        end else if (l) begin
            k = lookup(lv, w);
            if (k >= 0) begin
                n.q = lv;
                n.idx = k;
            end else begin
                n.q = sc ? 16'h0 : lv;
                n.idx = 0;
                n.err = 1'b1;
            end
        end else if (e) begin
            k = lookup(s.q, w);
            if (k < 0 && sc) begin
                n.q = '0;
                n.idx = 0;
            end else if (k < 0) begin
                // Illegal patterns follow the raw shift rule (e.g. 0101 -> 1011 forward).
                if (d) n.q = (s.q >> 1) | ({15'b0, ~s.q[0]} << (w - 1));
                else   n.q = ((s.q << 1) | {15'b0, ~s.q[w-1]}) & mask_of(w);
                nk = lookup(n.q, w);
                n.idx = (nk < 0) ? 0 : nk;
            end else begin
                if (d) nk = (k == 0) ? 2*w - 1 : k - 1;
                else   nk = (k == 2*w - 1) ? 0 : k + 1;
                n.wrap = d ? (k == 0) : (k == 2*w - 1);
                n.q = code(nk, w);
                n.idx = nk;
            end
        end
        return n;
    endfunction

    task automatic compare_one(input string tag, input logic [15:0] q, input int idx,
                               input logic wrap, input logic err, input logic ill, input int w);
        st_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, ".q"},       32'(q),    32'(e.q));
        check({tag, ".idx"},     32'(idx),  32'(e.idx));
        check({tag, ".wrap"},    32'(wrap), 32'(e.wrap));
        check({tag, ".err"},     32'(err),  32'(e.err));
        check({tag, ".illegal"}, 32'(ill),  32'(lookup(e.q, w) < 0));
    endtask

    task automatic cyc(input bit r, input bit l, input bit e, input bit d,
                       input logic [3:0] lv4, input logic [7:0] lv8);
        @(negedge clk);
        rst = r; ld = l; en = e; dir = d; ld_val4 = lv4; ld_val8 = lv8;
        ma = model_step(ma, r, l, e, d, {12'b0, lv4}, 4, 1'b1);
        mb = model_step(mb, r, l, e, d, {12'b0, lv4}, 4, 1'b0);
        mc = model_step(mc, r, l, e, d, {8'b0, lv8},  8, 1'b1);
        sb.push_back(ma);
        sb.push_back(mb);
        sb.push_back(mc);
        @(posedge clk);
        #1;
        compare_one("w4sc",  {12'b0, q_a}, int'(idx_a), wrap_a, err_a, ill_a, 4);
        compare_one("w4raw", {12'b0, q_b}, int'(idx_b), wrap_b, err_b, ill_b, 4);
        compare_one("w8sc",  {8'b0, q_c},  int'(idx_c), wrap_c, err_c, ill_c, 8);
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; en = 1'b0; dir = 1'b0; ld_val4 = '0; ld_val8 = '0;
        ma = '{q: '0, idx: 0, wrap: 1'b0, err: 1'b0};
        mb = ma;
        mc = ma;

        // Reset for two edges, then 32 forward steps (W4 wraps at 8,16,24,32; W8 at 16,32).
        cyc(1, 0, 0, 0, 4'h0, 8'h00);
        cyc(1, 0, 1, 0, 4'h0, 8'h00);
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 0, 4'h0, 8'h00);

        // Backward from zero: wrap on the first edge.
        cyc(1, 0, 0, 0, 4'h0, 8'h00);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1, 4'h0, 8'h00);

        // Legal load with en high, then a forward step.
        cyc(0, 1, 1, 0, 4'b0111, 8'h0F);
        cyc(0, 0, 1, 0, 4'h0, 8'h00);
        cyc(0, 0, 0, 0, 4'h0, 8'h00);

        // Illegal load, then steps both ways and a hold.
        cyc(0, 1, 0, 0, 4'b0101, 8'h55);
        cyc(0, 0, 1, 0, 4'h0, 8'h00);
        cyc(0, 0, 1, 0, 4'h0, 8'h00);
        cyc(0, 0, 0, 0, 4'h0, 8'h00);
        cyc(0, 0, 1, 1, 4'h0, 8'h00);
        cyc(0, 0, 1, 1, 4'h0, 8'h00);

        // Mid-sequence reset, then first forward step.
        cyc(0, 1, 0, 0, 4'b1100, 8'hF0);
        cyc(1, 0, 1, 0, 4'h0, 8'h00);
        cyc(0, 0, 1, 0, 4'h0, 8'h00);

        // Direction changes, random loads, holds and resets.
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 3) != 0),  1'($urandom_range(0, 1)),
                4'($urandom), 8'($urandom));
        end

        // Reset overrides a simultaneous load.
        cyc(1, 1, 1, 0, 4'b0111, 8'h3F);
        cyc(0, 0, 0, 0, 4'h0, 8'h00);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
